// File: rtl/dtree_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dtree_pkg
// Brief   : Shared types and defaults for the decision-tree vote sink:
//           FSM state encoding, class-code width, class count, counter width.
// Rev     : 1.0  initial release
// ============================================================================
package dtree_pkg;

  // Vote sink control states (explicit 2-bit encoding)
  typedef enum logic [1:0] {
    ST_ACCUM  = 2'd0,
    ST_SCAN   = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  localparam int C_CLASS_W     = 4;
  localparam int C_NUM_CLASSES = 10;
  localparam int C_CNT_W       = 8;

endpackage
`default_nettype wire

// File: rtl/dtree_vote_scan.sv
`default_nettype none
// ============================================================================
// Module  : dtree_vote_scan
// Brief   : Sequential argmax over the per-class vote counters. A start pulse
//           examines class 0; each following cycle examines the next class.
//           A later class wins only with a strictly larger count, so ties go
//           to the lowest index. done pulses once the last class is examined.
// Rev     : 1.0  initial release
// ============================================================================
module dtree_vote_scan
  import dtree_pkg::*;
#(
  parameter int NUM_CLASSES = C_NUM_CLASSES,
  parameter int CLASS_W     = C_CLASS_W
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic [NUM_CLASSES-1:0][C_CNT_W-1:0]   counts,
  output logic                                  done,
  output logic [CLASS_W-1:0]                    best_idx,
  output logic [C_CNT_W-1:0]                    best_cnt
);

  localparam int            IW     = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam logic [IW-1:0] C_LAST = IW'(NUM_CLASSES - 1);

  logic [IW-1:0]      r_idx;
  logic               r_busy;
  logic [C_CNT_W-1:0] w_cur;

  assign w_cur = counts[r_idx];

  // Walk the counters one class per cycle, keeping the running best
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx    <= '0;
      r_busy   <= 1'b0;
      done     <= 1'b0;
      best_idx <= '0;
      best_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        best_idx <= '0;
        best_cnt <= counts[0];
        r_idx    <= (NUM_CLASSES > 1) ? IW'(1) : '0;
        r_busy   <= (NUM_CLASSES > 1);
        done     <= (NUM_CLASSES == 1);
      end else if (r_busy) begin
        if (w_cur > best_cnt) begin
          best_cnt <= w_cur;
          best_idx <= CLASS_W'(r_idx);
        end
        if (r_idx == C_LAST) begin
          r_busy <= 1'b0;
          done   <= 1'b1;
        end else begin
          r_idx <= r_idx + IW'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dtree_vote_sink.sv
`default_nettype none
// ============================================================================
// Module  : dtree_vote_sink
// Brief   : Collects WIN legal class codes from a tree classifier, counts
//           votes per class, scans for the majority class and presents it
//           with its vote count over a valid/ready handshake.
//           Optional macro DTREE_VOTE_ERRCNT_EN adds err_cnt, a saturating
//           count of discarded illegal class codes (cleared only by reset).
// Rev     : 1.0  initial release
// ============================================================================
module dtree_vote_sink
  import dtree_pkg::*;
#(
  parameter int NUM_CLASSES = C_NUM_CLASSES,
  parameter int CLASS_W     = C_CLASS_W,
  parameter int WIN         = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CLASS_W-1:0] in_class,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CLASS_W-1:0] out_class,
  output logic [7:0]         out_votes
`ifdef DTREE_VOTE_ERRCNT_EN
  ,
  output logic [7:0]         err_cnt
`endif
);

  state_t                                r_state;
  logic [NUM_CLASSES-1:0][C_CNT_W-1:0]   r_cnt;
  logic [7:0]                            r_win;
  logic                                  r_scan_start;

  logic                                  w_accept;
  logic                                  w_legal;
  logic                                  w_last;
  logic                                  w_clear;
  logic                                  w_scan_done;
  logic [CLASS_W-1:0]                    w_best_idx;
  logic [C_CNT_W-1:0]                    w_best_cnt;

  assign in_ready = (r_state == ST_ACCUM);
  assign w_accept = in_valid && in_ready;
  assign w_legal  = w_accept && (32'(in_class) < NUM_CLASSES);
  assign w_last   = w_legal && (r_win == 8'(WIN - 1));
  // out_valid is high for the whole REPORT state, so this is the handshake
  assign w_clear  = (r_state == ST_REPORT) && out_ready;

  // Per-class vote counters: bump on a legal accept, wipe on result handoff
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_clear) begin
      r_cnt <= '0;
    end else if (w_legal) begin
      for (int k = 0; k < NUM_CLASSES; k++) begin
        if (in_class == CLASS_W'(k)) begin
          r_cnt[k] <= r_cnt[k] + C_CNT_W'(1);
        end
      end
    end
  end

  // Control FSM with registered result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_ACCUM;
      r_win        <= '0;
      r_scan_start <= 1'b0;
      out_valid    <= 1'b0;
      out_class    <= '0;
      out_votes    <= '0;
    end else begin
      r_scan_start <= 1'b0;
      case (r_state)
        ST_ACCUM: begin
          if (w_legal) begin
            r_win <= r_win + 8'd1;
            if (w_last) begin
              r_state      <= ST_SCAN;
              r_scan_start <= 1'b1;
            end
          end
        end
        ST_SCAN: begin
          if (w_scan_done) begin
            r_state   <= ST_REPORT;
            out_valid <= 1'b1;
            out_class <= w_best_idx;
            out_votes <= w_best_cnt;
          end
        end
        ST_REPORT: begin
          if (out_ready) begin
            r_state   <= ST_ACCUM;
            out_valid <= 1'b0;
            r_win     <= '0;
          end
        end
        default: r_state <= ST_ACCUM;
      endcase
    end
  end

  dtree_vote_scan #(
    .NUM_CLASSES (NUM_CLASSES),
    .CLASS_W     (CLASS_W)
  ) u_scan (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (r_scan_start),
    .counts   (r_cnt),
    .done     (w_scan_done),
    .best_idx (w_best_idx),
    .best_cnt (w_best_cnt)
  );

`ifdef DTREE_VOTE_ERRCNT_EN
  logic w_illegal;
  assign w_illegal = w_accept && !(32'(in_class) < NUM_CLASSES);

  // Saturating count of discarded illegal codes; only reset clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (w_illegal && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dtree_vote_sink.sv
`default_nettype none
// ============================================================================
// Module  : tb_dtree_vote_sink
// Brief   : Self-checking bench for dtree_vote_sink (default parameters).
//           Directed windows plus randomized windows compared against a
//           vote-tally reference model. Checks err_cnt when built with
//           DTREE_VOTE_ERRCNT_EN.
// Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dtree_vote_sink;

  localparam int NC  = 10;
  localparam int CW  = 4;
  localparam int WIN = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_class;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_class;
  logic [7:0]    out_votes;
`ifdef DTREE_VOTE_ERRCNT_EN
  logic [7:0]    err_cnt;
`endif

  dtree_vote_sink #(.NUM_CLASSES(NC), .CLASS_W(CW), .WIN(WIN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_class  (in_class),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_votes (out_votes)
`ifdef DTREE_VOTE_ERRCNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  always @(posedge clk) cyc++;

  // Reference model: plain vote tally of the current window
  int m_cnt[NC];
  int m_legal;
  int m_err;
  int acc_cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < NC; k++) m_cnt[k] = 0;
    m_legal = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int cls);
    in_valid = 1'b1;
    in_class = CW'(cls);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (cls < NC) begin
      m_cnt[cls]++;
      m_legal++;
      acc_cyc = cyc;
    end else if (m_err < 255) begin
      m_err++;
    end
  endtask

  // Wait for the result, compare it with the model, then hand it off
  task automatic finish_window(input string tag, input int hold, input bit pre_ready);
    int  eb;
    int  ec;
    bit  bad;
    eb = 0;
    ec = -1;
    for (int k = 0; k < NC; k++) begin
      if (m_cnt[k] > ec) begin
        ec = m_cnt[k];
        eb = k;
      end
    end
    out_ready = pre_ready;
    for (int i = 0; i < 60 && out_valid !== 1'b1; i++) begin
      @(posedge clk);
      #1;
      if (i == 2) check({tag, "_scan_rdy"}, in_ready, 0);
    end
    if (out_valid !== 1'b1) begin
      check({tag, "_timeout"}, 0, 1);
      out_ready = 1'b0;
      return;
    end
    check({tag, "_lat"},   cyc - acc_cyc, NC + 1);
    check({tag, "_class"}, out_class, eb);
    check({tag, "_votes"}, out_votes, ec);
    check({tag, "_rep_rdy"}, in_ready, 0);
`ifdef DTREE_VOTE_ERRCNT_EN
    check({tag, "_err"}, err_cnt, m_err);
`endif
    if (!pre_ready) begin
      bad = 1'b0;
      repeat (hold) begin
        @(posedge clk);
        #1;
        if (out_valid !== 1'b1 || out_class !== CW'(eb) || out_votes !== 8'(ec) || in_ready !== 1'b0)
          bad = 1'b1;
      end
      check({tag, "_stable"}, bad, 0);
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_drop"}, out_valid, 0);
    check({tag, "_acc_rdy"}, in_ready, 1);
    model_clear();
  endtask

  task automatic random_window(input string tag);
    int cls;
    int hi;
    hi = $urandom_range(1, NC - 1);
    while (m_legal < WIN) begin
      if ($urandom_range(0, 4) == 0) cls = $urandom_range(NC, (1 << CW) - 1);
      else                           cls = $urandom_range(0, hi);
      send(cls);
      if (m_legal < WIN && $urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    finish_window(tag, $urandom_range(0, 4), 1'($urandom_range(0, 1)));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=0 exp=1");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seq[$];
    bit bad;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_class  = '0;
    out_ready = 1'b0;
    m_err     = 0;
    acc_cyc   = 0;
    model_clear();
    idle(3);
    check("rst_valid", out_valid, 0);
    check("rst_class", out_class, 0);
    check("rst_votes", out_votes, 0);
    rst_n = 1'b1;
    idle(1);
    check("rst_ready", in_ready, 1);
`ifdef DTREE_VOTE_ERRCNT_EN
    check("rst_err", err_cnt, 0);
`endif

    // Plain majority
    seq = '{3, 3, 3, 5, 5, 1, 3, 7};
    foreach (seq[i]) send(seq[i]);
    finish_window("basic", 2, 1'b0);

    // Tie goes to the lower class index
    seq = '{2, 2, 2, 2, 6, 6, 6, 6};
    foreach (seq[i]) send(seq[i]);
    finish_window("tie", 1, 1'b0);

    // Illegal codes are accepted but not counted
    seq = '{9, 12, 9, 9, 15, 9, 9, 9, 9, 9};
    foreach (seq[i]) send(seq[i]);
    finish_window("illegal", 1, 1'b0);

    // Long backpressure in REPORT
    seq = '{0, 8, 8, 0, 8, 4, 4, 0};
    foreach (seq[i]) send(seq[i]);
    finish_window("hold", 5, 1'b0);

    // Reset during SCAN discards the window
    for (int i = 0; i < WIN; i++) send(1);
    idle(3);
    rst_n = 1'b0;
    #3;
    check("scanrst_valid", out_valid, 0);
    model_clear();
    m_err = 0;
    idle(2);
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) bad = 1'b1;
    end
    check("scanrst_quiet", bad, 0);
    for (int i = 0; i < WIN; i++) send(4);
    finish_window("after_rst", 1, 1'b0);

    // Downstream already ready at REPORT entry, then back-to-back window
    seq = '{7, 7, 0, 7, 11, 3, 3, 7, 2};
    foreach (seq[i]) send(seq[i]);
    finish_window("prerdy", 0, 1'b1);
    seq = '{5, 6, 6, 5, 6, 5, 5, 1};
    foreach (seq[i]) send(seq[i]);
    finish_window("next", 0, 1'b0);

    // Randomized windows
    for (int w = 0; w < 25; w++) random_window($sformatf("rnd%0d", w));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dtree_vote_sink.md
DTREE_VOTE_SINK -- requirements
Module: dtree_vote_sink

Interface
REQ-001 SHALL have parameter NUM_CLASSES, default 10: number of legal class codes, 0..NUM_CLASSES-1.
REQ-002 SHALL have parameter CLASS_W, default 4: class code width.
REQ-003 SHALL have parameter WIN, default 8, range 1..255: number of accepted samples per voting window.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  classifier result present.
REQ-007 in_ready  output  1  sink accepts a result this cycle.
REQ-008 in_class  input  CLASS_W  class code from the tree classifier.
REQ-009 out_valid  output  1  voted result present.
REQ-010 out_ready  input  1  downstream accepts the voted result.
REQ-011 out_class  output  CLASS_W  majority class of the window.
REQ-012 out_votes  output  8  vote count of out_class.

Function
REQ-013 SHALL implement FSM states ACCUM, SCAN, REPORT.
REQ-014 ACCUM: in_ready=1; each in_valid&in_ready cycle with in_class<NUM_CLASSES SHALL increment that class's 8-bit counter and the window counter.
REQ-015 in_class>=NUM_CLASSES SHALL be accepted and discarded: no counter change, window counter unchanged.
REQ-016 When the WIN-th legal sample is accepted, the FSM SHALL enter SCAN on the next cycle.
REQ-017 SCAN: in_ready=0; SHALL examine one class per cycle, index 0 upward, NUM_CLASSES cycles total; a class replaces the running best only if its count is strictly greater (ties resolve to the lowest index).
REQ-018 After the last class is examined, the FSM SHALL enter REPORT with out_valid=1, out_class=best, out_votes=best count.
REQ-019 out_class/out_votes SHALL be stable while out_valid=1 and out_ready=0.
REQ-020 On out_valid&out_ready, all class counters and the window counter SHALL clear in the same edge, and the FSM SHALL return to ACCUM; in_ready SHALL be 0 during REPORT.
REQ-021 Latency: the first out_valid SHALL assert NUM_CLASSES+1 cycles after the edge accepting the WIN-th sample.
REQ-022 Counters SHALL NOT wrap; WIN<=255 guarantees this.

Reset
REQ-023 rst_n low SHALL asynchronously force ACCUM, all counters 0, in_ready=1 once released, out_valid=0, out_class=0, out_votes=0.
REQ-024 Reset mid-SCAN or mid-REPORT SHALL discard the window with no output.

Configuration
REQ-025 Macro DTREE_VOTE_ERRCNT_EN defined: adds output err_cnt (8 bit, saturating at 255) counting discarded illegal codes; cleared only by reset.
REQ-026 Macro undefined: no err_cnt port; illegal codes are silently discarded.

Structure
REQ-027 Shared package dtree_pkg SHALL hold the FSM state enum, the class-code width constant, and NUM_CLASSES default.
REQ-028 Argmax scan SHALL be sub-module dtree_vote_scan (inputs: start, counter vector; outputs: done, best index, best count).

Verification
REQ-029 WIN=8, classes 3,3,3,5,5,1,3,7 -> out_class=3, out_votes=4, out_valid 11 cycles after the 8th accept.
REQ-030 Tie: four 2s then four 6s -> out_class=2, out_votes=4.
REQ-031 Illegal codes 12,15 interleaved among 8 legal 9s -> out_class=9, out_votes=8; err_cnt=2 with DTREE_VOTE_ERRCNT_EN defined.
REQ-032 out_ready held 0 for 5 cycles in REPORT -> out_class, out_votes, out_valid stable; in_ready=0 throughout.
REQ-033 rst_n asserted during SCAN -> out_valid never asserts; next window of eight 4s -> out_class=4, out_votes=8.
REQ-034 out_ready=1 at REPORT entry -> handshake in one cycle; next sample accepted with counters cleared.
